// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader uses the slave modport; the host/memory side uses master.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: LEN_LO, LEN_HI, 4*N little-endian data bytes, XOR CSUM.
// Holds the core in reset until an image with a matching checksum has been written.
module imem_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_WORDS = 2 ** (ADDR_W - 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  imem_loader_if.slave  ld_bus,
  output logic          core_hold_o,
  output logic          done_o,
  output logic          err_o
);

  localparam int unsigned IdxW = ADDR_W - 2;

  typedef enum logic [2:0] {
    StIdle, StLen0, StLen1, StData, StCsum, StDone, StErr
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [IdxW-1:0]     word_idx_q, word_idx_d;
  logic [23:0]         asm_q, asm_d;
  logic [7:0]          csum_q, csum_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                core_hold_q, core_hold_d;

  logic                in_ready;
  logic                hs;
  logic [15:0]         len_full;
  logic                last_word;

  assign in_ready  = (state_q == StLen0) || (state_q == StLen1) ||
                     (state_q == StData) || (state_q == StCsum);
  assign hs        = ld_bus.in_valid & in_ready;
  assign len_full  = {ld_bus.in_data, len_q[7:0]};
  // len_q >= 1 whenever DATA is entered, so the subtraction never underflows.
  assign last_word = (16'(word_idx_q) == (len_q - 16'd1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    word_idx_d  = word_idx_q;
    asm_d       = asm_q;
    csum_d      = csum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    err_d       = err_q;
    core_hold_d = core_hold_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) begin
          state_d     = StLen0;
          done_d      = 1'b0;
          err_d       = 1'b0;
          csum_d      = 8'h00;
          word_idx_d  = '0;
          byte_cnt_d  = 2'd0;
          core_hold_d = 1'b1;
        end
      end
      StLen0: begin
        if (hs) begin
          len_d[7:0] = ld_bus.in_data;
          state_d    = StLen1;
        end
      end
      StLen1: begin
        if (hs) begin
          len_d[15:8] = ld_bus.in_data;
          if (len_full == 16'd0) begin
            state_d = StCsum;
          end else if (len_full > 16'(MAX_WORDS)) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (hs) begin
          csum_d     = csum_q ^ ld_bus.in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          unique case (byte_cnt_q)
            2'd0: asm_d[7:0]   = ld_bus.in_data;
            2'd1: asm_d[15:8]  = ld_bus.in_data;
            2'd2: asm_d[23:16] = ld_bus.in_data;
            default: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = {word_idx_q, 2'b00};
              mem_wdata_d = {ld_bus.in_data, asm_q};
              word_idx_d  = word_idx_q + 1'b1;
              if (last_word) begin
                state_d = StCsum;
              end
            end
          endcase
        end
      end
      StCsum: begin
        if (hs) begin
          if (ld_bus.in_data == csum_q) begin
            state_d     = StDone;
            done_d      = 1'b1;
            core_hold_d = 1'b0;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_q       <= 16'h0000;
      byte_cnt_q  <= 2'd0;
      word_idx_q  <= '0;
      asm_q       <= 24'h000000;
      csum_q      <= 8'h00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      core_hold_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      word_idx_q  <= word_idx_d;
      asm_q       <= asm_d;
      csum_q      <= csum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      core_hold_q <= core_hold_d;
    end
  end

  assign ld_bus.in_ready  = in_ready;
  assign ld_bus.mem_we    = mem_we_q;
  assign ld_bus.mem_addr  = mem_addr_q;
  assign ld_bus.mem_wdata = mem_wdata_q;
  assign core_hold_o      = core_hold_q;
  assign done_o           = done_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal loads, bad checksum, length limits,
// gapped input with stray start, reload and mid-load reset.
module tb_imem_loader;

  logic clk;
  logic rst_n;
  logic start;
  logic core_hold;
  logic done;
  logic err;

  int checks;
  int errors;

  logic [7:0]  stim[$];
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(
    .ADDR_W    (8),
    .DATA_W    (32),
    .MAX_WORDS (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .ld_bus      (bus),
    .core_hold_o (core_hold),
    .done_o      (done),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_stream(input int gap);
    foreach (stim[i]) begin
      bus.in_valid = 1'b1;
      bus.in_data  = stim[i];
      @(posedge clk);
      #1;
      if (gap > 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hxx;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hxx;
  endtask

  task automatic clear_wr();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hxx;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_core_hold", 32'(core_hold), 32'd1);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check_eq("rst_done_err", {30'd0, done, err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // Reset while the first word's write strobe is out.
    pulse_start();
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    send_stream(0);
    check_eq("mid_we_before_rst", 32'(bus.mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_core_hold", 32'(core_hold), 32'd1);
    check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("mid_rst_done_err", {30'd0, done, err}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Good two-word image, back-to-back bytes.
    clear_wr();
    pulse_start();
    check_eq("t2_in_ready_len0", 32'(bus.in_ready), 32'd1);
    check_eq("t2_core_hold_load", 32'(core_hold), 32'd1);
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send_stream(0);
    settle();
    check_eq("t2_nwrites", 32'(wr_addr.size()), 32'd2);
    check_eq("t2_addr0", 32'(wr_addr[0]), 32'h00);
    check_eq("t2_data0", wr_data[0], 32'h0000_0013);
    check_eq("t2_addr1", 32'(wr_addr[1]), 32'h04);
    check_eq("t2_data1", wr_data[1], 32'h0010_0093);
    check_eq("t2_done", 32'(done), 32'd1);
    check_eq("t2_err", 32'(err), 32'd0);
    check_eq("t2_core_hold", 32'(core_hold), 32'd0);
    check_eq("t2_in_ready_done", 32'(bus.in_ready), 32'd0);
    check_eq("t2_addr_hold", 32'(bus.mem_addr), 32'h04);
    check_eq("t2_wdata_hold", bus.mem_wdata, 32'h0010_0093);

    // Same image with a wrong checksum.
    clear_wr();
    pulse_start();
    check_eq("t3_done_cleared", 32'(done), 32'd0);
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
    send_stream(0);
    settle();
    check_eq("t3_nwrites", 32'(wr_addr.size()), 32'd2);
    check_eq("t3_data1", wr_data[1], 32'h0010_0093);
    check_eq("t3_err", 32'(err), 32'd1);
    check_eq("t3_done", 32'(done), 32'd0);
    check_eq("t3_core_hold", 32'(core_hold), 32'd1);

    // Oversize length: 65 words rejected right after LEN_HI; later bytes ignored.
    clear_wr();
    pulse_start();
    check_eq("t4_err_cleared", 32'(err), 32'd0);
    stim = '{8'h41, 8'h00};
    send_stream(0);
    check_eq("t4_err", 32'(err), 32'd1);
    check_eq("t4_in_ready", 32'(bus.in_ready), 32'd0);
    stim = '{8'h13, 8'h00, 8'h00, 8'h00};
    send_stream(0);
    settle();
    check_eq("t4_nwrites", 32'(wr_addr.size()), 32'd0);
    check_eq("t4_core_hold", 32'(core_hold), 32'd1);

    // Largest legal image: 64 words, word k = k, XOR of all bytes is 0.
    clear_wr();
    pulse_start();
    stim = '{8'h40, 8'h00};
    for (int k = 0; k < 64; k++) begin
      stim.push_back(8'(k));
      stim.push_back(8'h00);
      stim.push_back(8'h00);
      stim.push_back(8'h00);
    end
    stim.push_back(8'h00);
    send_stream(0);
    settle();
    check_eq("tmax_nwrites", 32'(wr_addr.size()), 32'd64);
    check_eq("tmax_addr_last", 32'(wr_addr[63]), 32'hFC);
    check_eq("tmax_data_last", wr_data[63], 32'h0000_003F);
    check_eq("tmax_data_mid", wr_data[37], 32'h0000_0025);
    check_eq("tmax_done", 32'(done), 32'd1);

    // Empty image.
    clear_wr();
    pulse_start();
    stim = '{8'h00, 8'h00, 8'h00};
    send_stream(0);
    settle();
    check_eq("t5_n0_nwrites", 32'(wr_addr.size()), 32'd0);
    check_eq("t5_n0_done", 32'(done), 32'd1);
    check_eq("t5_n0_core_hold", 32'(core_hold), 32'd0);

    // Gapped bytes with a stray start during DATA.
    clear_wr();
    pulse_start();
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
    send_stream(2);
    pulse_start();
    stim = '{8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send_stream(1);
    settle();
    check_eq("t5_gap_nwrites", 32'(wr_addr.size()), 32'd2);
    check_eq("t5_gap_addr0", 32'(wr_addr[0]), 32'h00);
    check_eq("t5_gap_data0", wr_data[0], 32'h0000_0013);
    check_eq("t5_gap_addr1", 32'(wr_addr[1]), 32'h04);
    check_eq("t5_gap_data1", wr_data[1], 32'h0010_0093);
    check_eq("t5_gap_done", 32'(done), 32'd1);

    // Reload one word after DONE.
    clear_wr();
    pulse_start();
    check_eq("t6_core_hold_load", 32'(core_hold), 32'd1);
    check_eq("t6_done_cleared", 32'(done), 32'd0);
    stim = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    send_stream(0);
    settle();
    check_eq("t6_nwrites", 32'(wr_addr.size()), 32'd1);
    check_eq("t6_addr0", 32'(wr_addr[0]), 32'h00);
    check_eq("t6_data0", wr_data[0], 32'hDEAD_BEEF);
    check_eq("t6_done", 32'(done), 32'd1);
    check_eq("t6_core_hold", 32'(core_hold), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
